// File: rtl/vram_arbiter.sv
// ---------------------------------------------------------------------------
// vram_arbiter
//   Shares one single-port VRAM between the display scan-out engine and a CPU.
//   Scan-out always wins and is never stalled. CPU writes are posted into a
//   small FIFO and drained whenever scan-out leaves the port free. CPU reads
//   wait until every earlier posted write has drained, so a read always sees
//   the latest CPU data.
//
//   Ports
//     clk, rst          : clock, asynchronous active-low reset
//     disp_req/addr     : scan-out read request, issued the same cycle
//     disp_rvalid/rdata : scan-out read data, one cycle after issue
//     cpu_valid/we/addr/wdata, cpu_ready : CPU request handshake
//     cpu_rvalid/rdata  : CPU read data, one-cycle pulse
//     ram_en/we/addr/wdata, ram_rdata   : VRAM port (read latency 1)
//     wq_level          : posted-write queue occupancy
// ---------------------------------------------------------------------------
module vram_arbiter #(
  parameter int ADDR_W   = 13,
  parameter int DATA_W   = 8,
  parameter int WQ_DEPTH = 4   // power of 2, at least 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        disp_req,
  input  logic [ADDR_W-1:0]           disp_addr,
  output logic                        disp_rvalid,
  output logic [DATA_W-1:0]           disp_rdata,
  input  logic                        cpu_valid,
  input  logic                        cpu_we,
  input  logic [ADDR_W-1:0]           cpu_addr,
  input  logic [DATA_W-1:0]           cpu_wdata,
  output logic                        cpu_ready,
  output logic                        cpu_rvalid,
  output logic [DATA_W-1:0]           cpu_rdata,
  output logic                        ram_en,
  output logic                        ram_we,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic [$clog2(WQ_DEPTH):0]   wq_level
);

  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_PEND = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  // Who issued the VRAM access of the previous cycle; steers returning data.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_t;

  // Posted-write queue
  logic [ADDR_W-1:0] wq_addr_r [WQ_DEPTH];
  logic [DATA_W-1:0] wq_data_r [WQ_DEPTH];
  logic [PTR_W-1:0]  wq_head_r;
  logic [PTR_W-1:0]  wq_tail_r;
  logic [CNT_W-1:0]  wq_count_r;
  logic              wq_full_s;
  logic              wq_empty_s;
  logic              wq_push_s;
  logic              wq_pop_s;

  // CPU read tracking
  rd_state_t         rd_state_r;
  rd_state_t         rd_state_next_s;
  logic [ADDR_W-1:0] rd_addr_r;
  logic              rd_accept_s;
  logic              rd_issue_s;

  owner_t            owner_r;
  owner_t            owner_next_s;

  assign wq_full_s  = (wq_count_r == CNT_W'(WQ_DEPTH));
  assign wq_empty_s = (wq_count_r == {CNT_W{1'b0}});

  // Handshake: cpu_ready is a function of cpu_we and state only, so the CPU
  // can look at it before committing. Held low throughout reset.
  always_comb begin
    cpu_ready = 1'b0;
    if (!rst) begin
      cpu_ready = 1'b0;
    end else if (cpu_we) begin
      cpu_ready = !wq_full_s;
    end else begin
      // Reads wait behind every posted write and one read at a time.
      cpu_ready = wq_empty_s && (rd_state_r == RD_IDLE);
    end
  end

  assign wq_push_s   = cpu_valid && cpu_ready && cpu_we;
  assign rd_accept_s = cpu_valid && cpu_ready && !cpu_we;

  // Port arbitration: scan-out, then queue head, then pending CPU read.
  always_comb begin
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = {ADDR_W{1'b0}};
    ram_wdata    = {DATA_W{1'b0}};
    wq_pop_s     = 1'b0;
    rd_issue_s   = 1'b0;
    owner_next_s = OWN_NONE;
    if (!rst) begin
      ram_en = 1'b0;
    end else if (disp_req) begin
      ram_en       = 1'b1;
      ram_addr     = disp_addr;
      owner_next_s = OWN_DISP;
    end else if (!wq_empty_s) begin
      ram_en    = 1'b1;
      ram_we    = 1'b1;
      ram_addr  = wq_addr_r[wq_head_r];
      ram_wdata = wq_data_r[wq_head_r];
      wq_pop_s  = 1'b1;
    end else if (rd_state_r == RD_PEND) begin
      ram_en       = 1'b1;
      ram_addr     = rd_addr_r;
      rd_issue_s   = 1'b1;
      owner_next_s = OWN_CPU;
    end else begin
      // Nobody owns the port this cycle.
      ram_en = 1'b0;
    end
  end

  // Read FSM next-state logic.
  always_comb begin
    rd_state_next_s = rd_state_r;
    case (rd_state_r)
      RD_IDLE: begin
        if (rd_accept_s) begin
          rd_state_next_s = RD_PEND;
        end else begin
          rd_state_next_s = RD_IDLE;
        end
      end
      RD_PEND: begin
        if (rd_issue_s) begin
          rd_state_next_s = RD_DATA;
        end else begin
          rd_state_next_s = RD_PEND;
        end
      end
      RD_DATA: rd_state_next_s = RD_IDLE;
      default: rd_state_next_s = RD_IDLE;
    endcase
  end

  // Control state: queue pointers/count, read FSM, read address, owner tag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wq_head_r  <= {PTR_W{1'b0}};
      wq_tail_r  <= {PTR_W{1'b0}};
      wq_count_r <= {CNT_W{1'b0}};
      rd_state_r <= RD_IDLE;
      rd_addr_r  <= {ADDR_W{1'b0}};
      owner_r    <= OWN_NONE;
    end else begin
      rd_state_r <= rd_state_next_s;
      owner_r    <= owner_next_s;
      if (rd_accept_s) begin
        rd_addr_r <= cpu_addr;
      end
      if (wq_push_s) begin
        wq_tail_r <= wq_tail_r + PTR_W'(1'b1);
      end
      if (wq_pop_s) begin
        wq_head_r <= wq_head_r + PTR_W'(1'b1);
      end
      case ({wq_push_s, wq_pop_s})
        2'b10:   wq_count_r <= wq_count_r + CNT_W'(1'b1);
        2'b01:   wq_count_r <= wq_count_r - CNT_W'(1'b1);
        default: wq_count_r <= wq_count_r;
      endcase
    end
  end

  // Queue payload storage; entries are only meaningful while counted, so
  // they need no reset.
  always_ff @(posedge clk) begin
    if (wq_push_s) begin
      wq_addr_r[wq_tail_r] <= cpu_addr;
      wq_data_r[wq_tail_r] <= cpu_wdata;
    end
  end

  assign disp_rvalid = (owner_r == OWN_DISP);
  assign cpu_rvalid  = (rd_state_r == RD_DATA);
  assign disp_rdata  = ram_rdata;
  assign cpu_rdata   = ram_rdata;
  assign wq_level    = wq_count_r;

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        disp_req = 1'b0;
  logic [12:0] disp_addr = 13'h000;
  logic        disp_rvalid;
  logic [7:0]  disp_rdata;
  logic        cpu_valid = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = 13'h000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_ready;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        ram_en;
  logic        ram_we;
  logic [12:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [2:0]  wq_level;

  int n_pass   = 0;
  int n_checks = 0;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(13), .DATA_W(8), .WQ_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .disp_req(disp_req), .disp_addr(disp_addr),
    .disp_rvalid(disp_rvalid), .disp_rdata(disp_rdata),
    .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .wq_level(wq_level)
  );

  // VRAM model: unwritten locations read back their low address byte.
  logic [7:0] wr_mem [int];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) wr_mem[int'(ram_addr)] = ram_wdata;
      else if (wr_mem.exists(int'(ram_addr))) ram_rdata <= wr_mem[int'(ram_addr)];
      else ram_rdata <= ram_addr[7:0];
    end
  end

  typedef struct {
    logic        rst;
    logic        dreq;
    logic [12:0] daddr;
    logic        cv;
    logic        cwe;
    logic [12:0] caddr;
    logic [7:0]  cwd;
    logic        en;
    logic        we;
    logic [12:0] addr;
    logic [7:0]  wd;
    logic        rdy;
    logic        drv;
    logic [7:0]  drd;
    logic        crv;
    logic [7:0]  crd;
    logic [2:0]  lvl;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string tag, input int idx, input string fld,
                     input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d].%s: got 0x%0h, expected 0x%0h", tag, idx, fld, act, exp);
  endtask

  // Drive one cycle of inputs at the falling edge, check before the rising edge.
  task automatic run_vec(input string tag, input int idx, input vec_t v);
    @(negedge clk);
    rst       = v.rst;
    disp_req  = v.dreq;
    disp_addr = v.daddr;
    cpu_valid = v.cv;
    cpu_we    = v.cwe;
    cpu_addr  = v.caddr;
    cpu_wdata = v.cwd;
    #2;
    chk(tag, idx, "ram_en", 32'(ram_en), 32'(v.en));
    chk(tag, idx, "ram_we", 32'(ram_we), 32'(v.we));
    chk(tag, idx, "cpu_ready", 32'(cpu_ready), 32'(v.rdy));
    chk(tag, idx, "disp_rvalid", 32'(disp_rvalid), 32'(v.drv));
    chk(tag, idx, "cpu_rvalid", 32'(cpu_rvalid), 32'(v.crv));
    chk(tag, idx, "wq_level", 32'(wq_level), 32'(v.lvl));
    if (v.en) chk(tag, idx, "ram_addr", 32'(ram_addr), 32'(v.addr));
    if (v.en && v.we) chk(tag, idx, "ram_wdata", 32'(ram_wdata), 32'(v.wd));
    if (v.drv) chk(tag, idx, "disp_rdata", 32'(disp_rdata), 32'(v.drd));
    if (v.crv) chk(tag, idx, "cpu_rdata", 32'(cpu_rdata), 32'(v.crd));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // fields: rst dreq daddr cv cwe caddr cwd | en we addr wd rdy drv drd crv crd lvl
    // reset held: scan-out request and CPU write must be ignored
    tbl[0]  = '{1'b0,1'b1,13'h000,1'b1,1'b1,13'h1A5,8'h3C, 1'b0,1'b0,13'h000,8'h00,1'b0,1'b0,8'h00,1'b0,8'h00,3'd0};
    tbl[1]  = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    // single posted write 0x1A5 <- 0x3C
    tbl[2]  = '{1'b1,1'b0,13'h000,1'b1,1'b1,13'h1A5,8'h3C, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    tbl[3]  = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b1,1'b1,13'h1A5,8'h3C,1'b0,1'b0,8'h00,1'b0,8'h00,3'd1};
    tbl[4]  = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    // scan-out burst 0x0A0..0x0A2
    tbl[5]  = '{1'b1,1'b1,13'h0A0,1'b0,1'b0,13'h000,8'h00, 1'b1,1'b0,13'h0A0,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    tbl[6]  = '{1'b1,1'b1,13'h0A1,1'b0,1'b0,13'h000,8'h00, 1'b1,1'b0,13'h0A1,8'h00,1'b1,1'b1,8'hA0,1'b0,8'h00,3'd0};
    tbl[7]  = '{1'b1,1'b1,13'h0A2,1'b0,1'b0,13'h000,8'h00, 1'b1,1'b0,13'h0A2,8'h00,1'b1,1'b1,8'hA1,1'b0,8'h00,3'd0};
    tbl[8]  = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b1,8'hA2,1'b0,8'h00,3'd0};
    tbl[9]  = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    // write 0x010 <- 0x77, then read 0x010 must wait for the write
    tbl[10] = '{1'b1,1'b0,13'h000,1'b1,1'b1,13'h010,8'h77, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    tbl[11] = '{1'b1,1'b0,13'h000,1'b1,1'b0,13'h010,8'h00, 1'b1,1'b1,13'h010,8'h77,1'b0,1'b0,8'h00,1'b0,8'h00,3'd1};
    tbl[12] = '{1'b1,1'b0,13'h000,1'b1,1'b0,13'h010,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    tbl[13] = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b1,1'b0,13'h010,8'h00,1'b0,1'b0,8'h00,1'b0,8'h00,3'd0};
    tbl[14] = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b0,1'b0,8'h00,1'b1,8'h77,3'd0};
    tbl[15] = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    // read 0x020 held off by three scan-out cycles
    tbl[16] = '{1'b1,1'b0,13'h000,1'b1,1'b0,13'h020,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    tbl[17] = '{1'b1,1'b1,13'h030,1'b0,1'b0,13'h000,8'h00, 1'b1,1'b0,13'h030,8'h00,1'b0,1'b0,8'h00,1'b0,8'h00,3'd0};
    tbl[18] = '{1'b1,1'b1,13'h031,1'b0,1'b0,13'h000,8'h00, 1'b1,1'b0,13'h031,8'h00,1'b0,1'b1,8'h30,1'b0,8'h00,3'd0};
    tbl[19] = '{1'b1,1'b1,13'h032,1'b0,1'b0,13'h000,8'h00, 1'b1,1'b0,13'h032,8'h00,1'b0,1'b1,8'h31,1'b0,8'h00,3'd0};
    tbl[20] = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b1,1'b0,13'h020,8'h00,1'b0,1'b1,8'h32,1'b0,8'h00,3'd0};
    tbl[21] = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b0,1'b0,8'h00,1'b1,8'h20,3'd0};
    tbl[22] = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};

    for (int i = 0; i < 23; i++) run_vec("tbl", i, tbl[i]);

    // Queue fill under sustained scan-out: 4 of 5 writes accepted.
    for (int c = 0; c < 10; c++) begin
      int k;
      k = (c < 4) ? c : 4;
      v = '{1'b1,1'b1,13'h300 + 13'(c),1'b1,1'b1,13'h200 + 13'(k),8'hB0 + 8'(k),
            1'b1,1'b0,13'h300 + 13'(c),8'h00,(c < 4),(c > 0),8'(c - 1),1'b0,8'h00,3'(k)};
      run_vec("fill", c, v);
    end
    // Drain in order; full queue refuses the 5th write even while popping.
    v = '{1'b1,1'b0,13'h000,1'b1,1'b1,13'h204,8'hB4, 1'b1,1'b1,13'h200,8'hB0,1'b0,1'b1,8'h09,1'b0,8'h00,3'd4};
    run_vec("drain", 0, v);
    v = '{1'b1,1'b0,13'h000,1'b1,1'b1,13'h204,8'hB4, 1'b1,1'b1,13'h201,8'hB1,1'b1,1'b0,8'h00,1'b0,8'h00,3'd3};
    run_vec("drain", 1, v);
    for (int c = 2; c < 5; c++) begin
      v = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00,
            1'b1,1'b1,13'h200 + 13'(c),8'hB0 + 8'(c),1'b0,1'b0,8'h00,1'b0,8'h00,3'(5 - c)};
      run_vec("drain", c, v);
    end
    v = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    run_vec("drain", 5, v);

    // Reset with a pending read and three queued writes.
    v = '{1'b1,1'b0,13'h000,1'b1,1'b0,13'h040,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
    run_vec("rst", 0, v);
    for (int c = 1; c < 4; c++) begin
      v = '{1'b1,1'b1,13'h04F + 13'(c),1'b1,1'b1,13'h05F + 13'(c),8'hDF + 8'(c),
            1'b1,1'b0,13'h04F + 13'(c),8'h00,1'b1,(c > 1),8'h4E + 8'(c),1'b0,8'h00,3'(c - 1)};
      run_vec("rst", c, v);
    end
    v = '{1'b1,1'b1,13'h053,1'b0,1'b0,13'h000,8'h00, 1'b1,1'b0,13'h053,8'h00,1'b0,1'b1,8'h52,1'b0,8'h00,3'd3};
    run_vec("rst", 4, v);
    // Assert reset mid-cycle: outputs must clear without a clock edge.
    rst = 1'b0;
    #1;
    chk("async", 0, "ram_en", 32'(ram_en), 32'd0);
    chk("async", 0, "wq_level", 32'(wq_level), 32'd0);
    chk("async", 0, "cpu_ready", 32'(cpu_ready), 32'd0);
    chk("async", 0, "disp_rvalid", 32'(disp_rvalid), 32'd0);
    v = '{1'b0,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b0,1'b0,8'h00,1'b0,8'h00,3'd0};
    run_vec("rst", 5, v);
    for (int c = 6; c < 10; c++) begin
      v = '{1'b1,1'b0,13'h000,1'b0,1'b0,13'h000,8'h00, 1'b0,1'b0,13'h000,8'h00,1'b1,1'b0,8'h00,1'b0,8'h00,3'd0};
      run_vec("rst", c, v);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
